// File: rtl/mac_pkg.sv
// Shared constants and state type for the MAC accumulate-and-normalize stage.
package mac_pkg;

  localparam int REF_BIT    = 20;
  localparam int CARRY_BIT  = 21;
  localparam int DIFF_CLAMP = -16;
  localparam int MANT_W     = 11;
  // Lowest lead position that still yields an unclamped exponent adjustment.
  localparam int NORM_P_MIN = REF_BIT + DIFF_CLAMP;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_NORM,
    ST_OUT
  } acc_state_t;

endpackage

// File: rtl/mac_accum_norm_if.sv
// Term input / normalized result output bundle of mac_accum_norm.
interface mac_accum_norm_if #(
  parameter int TERM_W = 22
);
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic                in_sign;
  logic [TERM_W-1:0]   in_mag;
  logic [5:0]          in_max_exp;
  logic [4:0]          in_Q_frac;
  logic                out_valid;
  logic                out_ready;
  logic [10:0]         norm_sum_with_leading1;
  logic signed [4:0]   signed_exp_diff;
  logic                exp_carry;
  logic                sign;
  logic [5:0]          max_exp;
  logic [4:0]          Q_frac;
  logic                acc_ovf;

  modport master (
    output in_valid, in_last, in_sign, in_mag, in_max_exp, in_Q_frac, out_ready,
    input  in_ready, out_valid, norm_sum_with_leading1, signed_exp_diff,
           exp_carry, sign, max_exp, Q_frac, acc_ovf
  );

  modport slave (
    input  in_valid, in_last, in_sign, in_mag, in_max_exp, in_Q_frac, out_ready,
    output in_ready, out_valid, norm_sum_with_leading1, signed_exp_diff,
           exp_carry, sign, max_exp, Q_frac, acc_ovf
  );
endinterface

// File: rtl/lead_one_detect.sv
// Combinational priority encoder: index of the highest set bit plus an all-zero flag.
module lead_one_detect #(
  parameter int W  = 26,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [PW-1:0] pos,
  output logic          zero
);

  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        pos  = PW'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mac_accum_norm.sv
// Signed fixed-point accumulation of aligned products followed by leading-one normalization.
// Build option: define ACC_SAT_EN to saturate the accumulator instead of wrapping.
module mac_accum_norm
  import mac_pkg::*;
#(
  parameter int ACC_W  = 26,
  parameter int TERM_W = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  mac_accum_norm_if.slave bus
);

  localparam int PW = $clog2(ACC_W);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  // Returns {overflow, sum}; the sum is either wrapped or saturated to +/-ACC_MAX.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    logic                    ovf;
    s   = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
`ifdef ACC_SAT_EN
    if (ovf) s = a[ACC_W-1] ? -ACC_MAX : ACC_MAX;
`endif
    return {ovf, s};
  endfunction

  // Window mag[pe : pe-MANT_W+1], with positions below bit 0 reading as zero.
  function automatic logic [MANT_W-1:0] mant_window(input logic [ACC_W-1:0] m,
                                                    input logic [PW-1:0]    pe);
    logic [ACC_W+MANT_W-2:0] ext;
    ext = {m, {(MANT_W-1){1'b0}}};
    return MANT_W'(ext >> pe);
  endfunction

  acc_state_t              state;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] term_p0;
  logic [ACC_W:0]          add_p0;
  logic [ACC_W-1:0]        mag_p0;
  logic [PW-1:0]           lead_p0;
  logic                    zero_p0;
  logic                    acc_ovf_p0;
  logic                    in_ready_q;
  logic [5:0]              max_exp_p0;
  logic [4:0]              q_frac_p0;

  always_comb begin
    term_p0 = signed'({{(ACC_W-TERM_W){1'b0}}, bus.in_mag});
    if (bus.in_sign) term_p0 = -term_p0;
  end

  assign add_p0 = acc_add(acc_p0, term_p0);
  assign mag_p0 = acc_p0[ACC_W-1] ? ACC_W'(-acc_p0) : ACC_W'(acc_p0);

  lead_one_detect #(.W(ACC_W), .PW(PW)) u_lod (
    .vec  (mag_p0),
    .pos  (lead_p0),
    .zero (zero_p0)
  );

  logic vld_p1;
  logic vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      acc_p0     <= '0;
      acc_ovf_p0 <= 1'b0;
      in_ready_q <= 1'b1;
      max_exp_p0 <= '0;
      q_frac_p0  <= '0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            acc_p0     <= term_p0;
            acc_ovf_p0 <= 1'b0;
            max_exp_p0 <= bus.in_max_exp;
            q_frac_p0  <= bus.in_Q_frac;
            state      <= bus.in_last ? ST_NORM : ST_ACCUM;
            in_ready_q <= ~bus.in_last;
          end
        end
        ST_ACCUM: begin
          if (bus.in_valid) begin
            acc_p0     <= signed'(add_p0[ACC_W-1:0]);
            acc_ovf_p0 <= acc_ovf_p0 | add_p0[ACC_W];
            if (bus.in_last) begin
              state      <= ST_NORM;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_NORM: begin
          vld_p1 <= 1'b1;
          state  <= ST_OUT;
        end
        default: begin
          vld_p1 <= 1'b0;
          if (vld_p1) vld_p2 <= 1'b1;
          if (vld_p2 && bus.out_ready) begin
            vld_p2     <= 1'b0;
            acc_p0     <= '0;
            acc_ovf_p0 <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // ---- stage p1: sign, magnitude and lead position of the finished sum ----
  logic             sign_p1;
  logic [ACC_W-1:0] mag_p1;
  logic [PW-1:0]    lead_p1;
  logic             zero_p1;

  always_ff @(posedge clk) begin
    if (state == ST_NORM) begin
      sign_p1 <= acc_p0[ACC_W-1];
      mag_p1  <= mag_p0;
      lead_p1 <= lead_p0;
      zero_p1 <= zero_p0;
    end
  end

  logic              carry_p1;
  logic [PW-1:0]     pe_p1;
  logic signed [4:0] diff_p1;

  always_comb begin
    carry_p1 = (int'(lead_p1) >= CARRY_BIT);
    pe_p1    = lead_p1;
    if (carry_p1) begin
      diff_p1 = 5'(int'(lead_p1) - CARRY_BIT);
    end else if (int'(lead_p1) < NORM_P_MIN) begin
      pe_p1   = PW'(NORM_P_MIN);
      diff_p1 = 5'(DIFF_CLAMP);
    end else begin
      diff_p1 = 5'(int'(lead_p1) - REF_BIT);
    end
  end

  // ---- stage p2: held result registers ----
  logic [MANT_W-1:0] norm_p2;
  logic signed [4:0] diff_p2;
  logic              carry_p2;
  logic              sign_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      norm_p2  <= '0;
      diff_p2  <= '0;
      carry_p2 <= 1'b0;
      sign_p2  <= 1'b0;
    end else if (vld_p1) begin
      norm_p2  <= zero_p1 ? '0 : mant_window(mag_p1, pe_p1);
      diff_p2  <= zero_p1 ? '0 : diff_p1;
      carry_p2 <= ~zero_p1 & carry_p1;
      sign_p2  <= ~zero_p1 & sign_p1;
    end
  end

  assign bus.in_ready               = in_ready_q;
  assign bus.out_valid              = vld_p2;
  assign bus.norm_sum_with_leading1 = norm_p2;
  assign bus.signed_exp_diff        = diff_p2;
  assign bus.exp_carry              = carry_p2;
  assign bus.sign                   = sign_p2;
  assign bus.max_exp                = max_exp_p0;
  assign bus.Q_frac                 = q_frac_p0;
  assign bus.acc_ovf                = acc_ovf_p0;

endmodule

// File: doc/mac_accum_norm.md
# mac_accum_norm

Accumulate-and-normalize stage feeding the FP16 exponent/normalization handler in the MAC subsystem. It accepts a stream of products that are already aligned to a common `max_exp`, and sums them in a signed fixed-point accumulator. On the last term of a group it runs leading-one detection and emits `norm_sum_with_leading1`, `signed_exp_diff`, `exp_carry`, `sign`, `max_exp` and `Q_frac` through a valid/ready output register.

## Interface
- `ACC_W`, 26: accumulator width, two's complement; legal range 24..32.
- `TERM_W`, 22: magnitude width of one aligned product term.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: term present.
- `in_ready` out 1: stage accepts a term.
- `in_last` in 1: term closes the group.
- `in_sign` in 1: term sign (1 = negative).
- `in_mag` in TERM_W: term magnitude; reference bit is 20 (value 1.0).
- `in_max_exp` in 6: group exponent; sampled on the first term of a group.
- `in_Q_frac` in 5: fraction-position offset; sampled with `in_max_exp`.
- `out_valid` out 1: result held.
- `out_ready` in 1: downstream accepts.
- `norm_sum_with_leading1` out 11: truncated mantissa window.
- `signed_exp_diff` out 5: signed exponent adjustment.
- `exp_carry` out 1: leading one at or above bit 21.
- `sign` out 1: sign of the sum.
- `max_exp` out 6: latched group exponent.
- `Q_frac` out 5: latched offset.
- `acc_ovf` out 1: sticky per group; set when accumulation overflowed.

## Operation
- States:
  - IDLE: `in_ready`=1. An accepted term loads `acc` = ±`in_mag` and latches `max_exp`/`Q_frac`. The next state is ACCUM, or NORM if `in_last`.
  - ACCUM: `in_ready`=1. An accepted term does `acc += ±in_mag`. It moves to NORM on `in_last`.
  - NORM: `in_ready`=0. Registers sign, magnitude and lead position `p`. Goes to OUT.
  - OUT: `in_ready`=0. Outputs held, `out_valid`=1. On `out_ready`, goes to IDLE and clears `acc` and `acc_ovf`.
- Term handling: the term is zero-extended to ACC_W and negated when `in_sign`=1.
- Magnitude: `mag` = |acc| as an ACC_W-bit unsigned value. -2^(ACC_W-1) yields `mag` = 2^(ACC_W-1).
- Zero sum: norm=0, diff=0, carry=0, sign=0.
- Nonzero sum, with `p` the index of the highest set bit of `mag`:
  - If `p`≥21: `exp_carry`=1 and `signed_exp_diff`=`p`−21.
  - Otherwise: `exp_carry`=0 and `signed_exp_diff`=`p`−20.
  - Clamp: if `p`<4, treat `p` as 4 and set diff to −16.
  - Mantissa: `norm_sum_with_leading1` = `mag[p : p−10]`. Bits below 0 read as zero. Truncation only, no rounding.
- Group length is ≥1 term; `in_last` on the first term is legal.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0. Every other output is 0. State is IDLE and `acc`=0.
- Reset mid-group discards the partial group immediately, since the reset is asynchronous.
- Latency: last term accepted at edge N; `out_valid` rises after edge N+2.
- Throughput: one term per cycle within a group. There are 2 bubble cycles plus output-hold cycles between groups.
- Outputs stay stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` is ignored whenever `in_ready`=0.

## Configuration
- `ACC_SAT_EN` defined:
  - The accumulator saturates to +(2^(ACC_W-1)−1) or −(2^(ACC_W-1)−1).
  - Any saturation sets `acc_ovf`.
- `ACC_SAT_EN` undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - `acc_ovf` still flags a signed overflow.

## Structure
- Package `mac_pkg`:
  - Reference bit (20).
  - Carry bit (21).
  - Diff clamp (−16).
  - Mantissa width (11).
  - State enum `acc_state_t`.
- Sub-module `lead_one_detect`: combinational priority encoder over ACC_W bits, returning `p` and a zero flag.

## Test plan
- Single term +0x100000, last → norm=0x400, diff=0, carry=0, sign=0, `out_valid` 2 cycles after accept.
- Terms 0x100000 + 0x100000 → `mag`=0x200000 → carry=1, diff=0, norm=0x400.
- Terms +0x180000 then −0x180000 → norm=0, diff=0, carry=0, sign=0.
- Single term −0x000400 → sign=1, diff=−10, norm=0x400.
- Single term 0x000004 → diff=−16 (clamped), norm=0x100.
- Saturation/wrap, 16 terms of 0x3FFFFF with ACC_W=26:
  - With `ACC_SAT_EN`: norm=0x7FF, carry=1, diff=3, `acc_ovf`=1.
  - Without: sum wraps to −16 → sign=1, diff=−16, norm=0x400, `acc_ovf`=1.
- Backpressure and reset:
  - Hold `out_ready`=0 for 3 cycles → outputs stable and `in_ready`=0.
  - Assert `rst_n` low mid-group → outputs clear immediately, and the next group starts fresh.
